// File: rtl/hash_lut_loader.sv
// Avalon-MM write master that clears the Bloom-filter hash LUT and then sets one bit per hash beat.
// Optional statistics outputs are enabled by defining HASH_LUT_LOADER_STAT_EN.
//
// state  | meaning
// IDLE   | no session, outputs quiet
// CLEAR  | writing 0 to every LUT bit, ascending address
// LOAD   | accepting beats, each in-range beat becomes one set-write
// DRAIN  | finish seen, waiting for the last set-write to be accepted
module hash_lut_loader #(
    parameter int AMM_LUT_ADDR_W = 32,
    parameter int AMM_LUT_DATA_W = 32,
    parameter int MAX_STR_SIZE   = 20,
    parameter int MIN_STR_SIZE   = 8,
    parameter int HASHES_CNT     = 6,
    parameter int HASH_W         = 12,
    parameter int MODE           = 0,
    localparam int LEN_W         = $clog2(MAX_STR_SIZE + 1),
    localparam int IDX_W         = $clog2(HASHES_CNT)
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic                      start_i,
    input  logic                      finish_i,
    input  logic [LEN_W-1:0]          s_len_i,
    input  logic [IDX_W-1:0]          s_idx_i,
    input  logic [HASH_W-1:0]         s_hash_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic [AMM_LUT_ADDR_W-1:0] amm_master_lut_address_o,
    output logic                      amm_master_lut_write_o,
    output logic [AMM_LUT_DATA_W-1:0] amm_master_lut_writedata_o,
    input  logic                      amm_master_lut_waitrequest_i,
    output logic                      config_o,
    output logic                      busy_o,
    output logic                      err_o
`ifdef HASH_LUT_LOADER_STAT_EN
    ,
    output logic [31:0]               stat_set_cnt_o,
    output logic [31:0]               stat_drop_cnt_o
`endif
);

    localparam int AW     = AMM_LUT_ADDR_W;
    localparam int S      = MAX_STR_SIZE - MIN_STR_SIZE + 1;
    localparam bit PACK   = (MODE == 0) && (HASH_W < 13);
    localparam int W      = PACK ? 13 : HASH_W;
    localparam int BLK    = (MODE == 1) ? S * (HASHES_CNT / 2) :
                            PACK        ? (S * HASHES_CNT + 1) / 2 : S * HASHES_CNT;
    localparam logic [AW-1:0] CLR_LAST = AW'((longint'(BLK) << W) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_DRAIN
    } state_t;

    state_t         r_state;
    logic           r_write;
    logic           r_data;
    logic [AW-1:0]  r_addr;
    logic           r_err;

    logic           w_wr_done;
    logic           w_accept;
    logic           w_beat_ok;
    logic [31:0]    w_f;
    logic [AW-1:0]  w_beat_addr;

    assign w_wr_done = r_write && !amm_master_lut_waitrequest_i;
    assign s_ready_o = (r_state == ST_LOAD) && (!r_write || !amm_master_lut_waitrequest_i);
    assign w_accept  = s_valid_i && s_ready_o;
    assign w_beat_ok = (32'(s_len_i) >= 32'(MIN_STR_SIZE)) &&
                       (32'(s_len_i) <= 32'(MAX_STR_SIZE)) &&
                       (32'(s_idx_i) <  32'(HASHES_CNT));

    // w_f is garbage for out-of-range beats, but those never reach the write path
    always_comb begin
        w_f = (32'(s_len_i) - 32'(MIN_STR_SIZE)) * 32'(HASHES_CNT) + 32'(s_idx_i);
        if (MODE == 1)
            w_beat_addr = (AW'(w_f >> 1) << W) | AW'(s_hash_i);
        else if (PACK)
            w_beat_addr = (AW'(w_f >> 1) << W) | (AW'(w_f[0]) << HASH_W) | AW'(s_hash_i);
        else
            w_beat_addr = (AW'(w_f) << W) | AW'(s_hash_i);
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= ST_IDLE;
            r_write <= 1'b0;
            r_data  <= 1'b0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_CLEAR;
                        r_addr  <= '0;
                        r_data  <= 1'b0;
                        r_write <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (w_wr_done) begin
                        if (r_addr == CLR_LAST) begin
                            r_state <= ST_LOAD;
                            r_write <= 1'b0;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_wr_done)
                        r_write <= 1'b0;
                    if (w_accept) begin
                        if (w_beat_ok) begin
                            r_write <= 1'b1;
                            r_data  <= 1'b1;
                            r_addr  <= w_beat_addr;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    if (finish_i)
                        r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!r_write || w_wr_done) begin
                        r_state <= ST_IDLE;
                        r_write <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef HASH_LUT_LOADER_STAT_EN
    logic [31:0] r_set_cnt;
    logic [31:0] r_drop_cnt;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_set_cnt  <= '0;
            r_drop_cnt <= '0;
        end else if (r_state == ST_IDLE && start_i) begin
            r_set_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr_done && r_data && !(&r_set_cnt))
                r_set_cnt <= r_set_cnt + 1'b1;
            if (w_accept && !w_beat_ok && !(&r_drop_cnt))
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign stat_set_cnt_o  = r_set_cnt;
    assign stat_drop_cnt_o = r_drop_cnt;
`endif

    // config and busy share one source so they can never drop on different cycles
    assign config_o                   = (r_state != ST_IDLE);
    assign busy_o                     = (r_state != ST_IDLE);
    assign err_o                      = r_err;
    assign amm_master_lut_write_o     = r_write;
    assign amm_master_lut_address_o   = r_addr;
    assign amm_master_lut_writedata_o = AMM_LUT_DATA_W'(r_data);

endmodule

// File: tb/tb_hash_lut_loader.sv
// Scoreboard bench for hash_lut_loader with a reduced geometry (lengths 8..9, 3 hashes, W=13, 3 blocks).
// Stat outputs are checked only when HASH_LUT_LOADER_STAT_EN is defined.
module tb_hash_lut_loader;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MAXS  = 9;
    localparam int MINS  = 8;
    localparam int HC    = 3;
    localparam int HW    = 12;
    localparam int LEN_W = $clog2(MAXS + 1);
    localparam int IDX_W = $clog2(HC);
    localparam int CLR_N = 3 * 8192;

    typedef struct packed {
        logic [31:0] addr;
        logic        data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             finish = 1'b0;
    logic [LEN_W-1:0] s_len = '0;
    logic [IDX_W-1:0] s_idx = '0;
    logic [HW-1:0]    s_hash = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [AW-1:0]    addr;
    logic             wr;
    logic [DW-1:0]    wdata;
    logic             waitreq = 1'b0;
    logic             cfg;
    logic             busy;
    logic             err;
`ifdef HASH_LUT_LOADER_STAT_EN
    logic [31:0]      stat_set;
    logic [31:0]      stat_drop;
`endif

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    longint set_cyc[$];
    exp_t   sb[$];
    exp_t   mon_e;

    hash_lut_loader #(
        .AMM_LUT_ADDR_W(AW), .AMM_LUT_DATA_W(DW), .MAX_STR_SIZE(MAXS),
        .MIN_STR_SIZE(MINS), .HASHES_CNT(HC), .HASH_W(HW), .MODE(0)
    ) dut (
        .clk_i                        (clk),
        .arst_n_i                     (rst_n),
        .start_i                      (start),
        .finish_i                     (finish),
        .s_len_i                      (s_len),
        .s_idx_i                      (s_idx),
        .s_hash_i                     (s_hash),
        .s_valid_i                    (s_valid),
        .s_ready_o                    (s_ready),
        .amm_master_lut_address_o     (addr),
        .amm_master_lut_write_o       (wr),
        .amm_master_lut_writedata_o   (wdata),
        .amm_master_lut_waitrequest_i (waitreq),
        .config_o                     (cfg),
        .busy_o                       (busy),
        .err_o                        (err)
`ifdef HASH_LUT_LOADER_STAT_EN
        ,
        .stat_set_cnt_o               (stat_set),
        .stat_drop_cnt_o              (stat_drop)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples after the stimulus has settled inputs for the coming rising edge
    always begin
        @(negedge clk);
        #2;
        if (rst_n && wr && !waitreq) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", addr, wdata);
            end else begin
                mon_e = sb.pop_front();
                chk("lut_write", {addr, wdata}, {mon_e.addr, 32'(mon_e.data)});
                if (mon_e.data)
                    set_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_clear(input int n);
        for (int i = 0; i < n; i++)
            sb.push_back('{addr: 32'(i), data: 1'b0});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input int len, input int idx, input int hash,
                        input bit exp_wr, input logic [31:0] exp_addr, input bit fin);
        bit done = 1'b0;
        s_len   = LEN_W'(len);
        s_idx   = IDX_W'(idx);
        s_hash  = HW'(hash);
        s_valid = 1'b1;
        finish  = fin;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (s_ready) begin
                if (exp_wr)
                    sb.push_back('{addr: exp_addr, data: 1'b1});
                @(negedge clk);
                #1;
                done = 1'b1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        finish  = 1'b0;
        chk("beat_accepted", 64'(done), 64'd1);
    endtask

    task automatic wait_load();
        for (int n = 0; n < CLR_N + 100; n++) begin
            step();
            if (s_ready) break;
        end
        chk("load_reached", 64'(s_ready), 64'd1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20; n++) begin
            chk("config_eq_busy", 64'(cfg), 64'(busy));
            if (!busy) break;
            step();
        end
        chk("idle_reached", 64'(busy), 64'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_write"}, 64'(wr), 64'd0);
        chk({tag, "_addr"}, 64'(addr), 64'd0);
        chk({tag, "_data"}, 64'(wdata), 64'd0);
        chk({tag, "_config"}, 64'(cfg), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_ready"}, 64'(s_ready), 64'd0);
    endtask

    initial begin
        step();
        step();
        chk_quiet("reset");
        rst_n = 1'b1;
        step();

        // full clear; a finish pulse in CLEAR must not end the session
        push_clear(CLR_N);
        pulse_start();
        step();
        finish = 1'b1;
        step();
        finish = 1'b0;
        step();
        step();
        chk("finish_in_clear_busy", 64'(busy), 64'd1);
        chk("clear_ready_low", 64'(s_ready), 64'd0);
        wait_load();
        chk("clear_all_written", 64'(sb.size()), 64'd0);

        // back-to-back beats, one set-write per cycle
        set_cyc.delete();
        send(8, 0, 'h005, 1'b1, 32'h00005, 1'b0);
        send(8, 1, 'hABC, 1'b1, 32'h01ABC, 1'b0);
        send(9, 0, 'h123, 1'b1, 32'h03123, 1'b0);
        step();
        step();
        chk("b2b_count", 64'(set_cyc.size()), 64'd3);
        if (set_cyc.size() == 3)
            chk("b2b_spacing", 64'(set_cyc[2] - set_cyc[0]), 64'd2);

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("start_busy_ignored", 64'(busy), 64'd1);
        chk("start_busy_still_load", 64'(s_ready), 64'd1);

        // three stalled cycles on a set-write
        waitreq = 1'b1;
        send(9, 2, 'h7FF, 1'b1, 32'h057FF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("stall_write", 64'(wr), 64'd1);
            chk("stall_addr", 64'(addr), 64'h057FF);
            if (k < 3) begin
                chk("stall_ready", 64'(s_ready), 64'd0);
                step();
            end
        end
        waitreq = 1'b0;
        step();
        chk("stall_released", 64'(wr), 64'd0);

        // out-of-range beats are swallowed
        chk("err_before", 64'(err), 64'd0);
        send(10, 0, 'h001, 1'b0, 32'h0, 1'b0);
        send(8, 3, 'h001, 1'b0, 32'h0, 1'b0);
        send(7, 0, 'h001, 1'b0, 32'h0, 1'b0);
        step();
        chk("err_set", 64'(err), 64'd1);
        chk("err_no_write", 64'(sb.size()), 64'd0);

        // beat together with finish is still written, then drain
        send(8, 2, 'hFFF, 1'b1, 32'h02FFF, 1'b1);
        wait_idle();
        chk("drain_all_written", 64'(sb.size()), 64'd0);
        chk("err_sticky_idle", 64'(err), 64'd1);
`ifdef HASH_LUT_LOADER_STAT_EN
        chk("stat_set", 64'(stat_set), 64'd5);
        chk("stat_drop", 64'(stat_drop), 64'd3);
`endif

        // new session clears err; reset while clearing address 0x100
        push_clear(256);
        pulse_start();
        chk("err_cleared", 64'(err), 64'd0);
`ifdef HASH_LUT_LOADER_STAT_EN
        chk("stat_set_cleared", 64'(stat_set), 64'd0);
        chk("stat_drop_cleared", 64'(stat_drop), 64'd0);
`endif
        for (int n = 0; n < 400; n++) begin
            if (wr && addr == 32'h100) break;
            step();
        end
        chk("clear_reached_100", 64'(addr), 64'h100);
        rst_n = 1'b0;
        step();
        chk_quiet("midclear_reset");
        chk("midclear_sb", 64'(sb.size()), 64'd0);
        rst_n = 1'b1;
        step();

        push_clear(CLR_N);
        pulse_start();
        chk("restart_addr0", 64'(addr), 64'd0);
        wait_load();
        chk("restart_all_written", 64'(sb.size()), 64'd0);
        finish = 1'b1;
        step();
        finish = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
